// File: rtl/mine_board_renderer.sv
// Minesweeper board renderer: 640x480 VGA timing from a divided system clock,
// a two-stage pixel pipeline fed by an external synchronous status RAM, and a
// frame-synchronous cursor driven by edge-detected buttons.
module mine_board_renderer #(
    parameter int GRID_COLS    = 5,
    parameter int GRID_ROWS    = 5,
    parameter int CELL_SHIFT   = 6,
    parameter int ORIGIN_X     = 64,
    parameter int ORIGIN_Y     = 64,
    parameter int PIX_DIV      = 4,
    parameter int WRAP         = 0,
    parameter int HILITE_MODE  = 0,
    parameter logic [11:0] CURSOR_COLOR = 12'h777,
    parameter logic [11:0] BG_COLOR     = 12'h000,
    localparam int ADDR_W = (GRID_COLS * GRID_ROWS > 1) ? $clog2(GRID_COLS * GRID_ROWS) : 1,
    localparam int COL_W  = (GRID_COLS > 1) ? $clog2(GRID_COLS) : 1,
    localparam int ROW_W  = (GRID_ROWS > 1) ? $clog2(GRID_ROWS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_left,
    input  logic              btn_right,
    input  logic              btn_up,
    input  logic              btn_down,
    output logic [ADDR_W-1:0] cell_addr,
    input  logic [3:0]        cell_data,
    output logic [COL_W-1:0]  cursor_col,
    output logic [ROW_W-1:0]  cursor_row,
    output logic              frame_start,
    output logic              hSync,
    output logic              vSync,
    output logic [3:0]        VGA_R,
    output logic [3:0]        VGA_G,
    output logic [3:0]        VGA_B
);
    localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(GRID_COLS - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(GRID_ROWS - 1);

    logic [DIV_W-1:0]  div_reg;
    logic              pix_en;
    logic [9:0]        h_reg, v_reg;
    logic [9:0]        dx, dy, col_idx, row_idx;
    logic [CELL_SHIFT-1:0] lo_x, lo_y;
    logic              in_board, cursor_hit, border_hit;
    logic              active_reg, board_reg, cursor_hit_reg, border_reg, hs1_reg, vs1_reg;
    logic [ADDR_W-1:0] cell_addr_reg;
    logic [11:0]       pal_color, colour_next, rgb_reg;
    logic              hsync_reg, vsync_reg;
    logic [3:0]        btn_vec, rise, pending;
    logic [COL_W-1:0]  cursor_col_reg, cursor_col_next;
    logic [ROW_W-1:0]  cursor_row_reg, cursor_row_next;

    assign pix_en      = (div_reg == DIV_W'(PIX_DIV - 1));
    // Gated by reset so no pulse escapes while the block is held in reset.
    assign frame_start = reset && pix_en && (h_reg == 10'd0) && (v_reg == 10'd0);

    // Pixel-rate divider.
    always_ff @(posedge clk) begin
        if (!reset)      div_reg <= '0;
        else if (pix_en) div_reg <= '0;
        else             div_reg <= div_reg + DIV_W'(1);
    end

    // Horizontal/vertical raster counters (800 x 525).
    always_ff @(posedge clk) begin
        if (!reset) begin
            h_reg <= '0;
            v_reg <= '0;
        end else if (pix_en) begin
            if (h_reg == 10'd799) begin
                h_reg <= '0;
                v_reg <= (v_reg == 10'd524) ? 10'd0 : v_reg + 10'd1;
            end else begin
                h_reg <= h_reg + 10'd1;
            end
        end
    end

    // Board geometry of the pixel currently issued by the counters.
    always_comb begin
        dx         = h_reg - 10'(ORIGIN_X);
        dy         = v_reg - 10'(ORIGIN_Y);
        col_idx    = dx >> CELL_SHIFT;
        row_idx    = dy >> CELL_SHIFT;
        lo_x       = dx[CELL_SHIFT-1:0];
        lo_y       = dy[CELL_SHIFT-1:0];
        in_board   = (h_reg >= 10'(ORIGIN_X)) && (v_reg >= 10'(ORIGIN_Y)) &&
                     (col_idx < 10'(GRID_COLS)) && (row_idx < 10'(GRID_ROWS));
        cursor_hit = (col_idx == 10'(cursor_col_reg)) && (row_idx == 10'(cursor_row_reg));
        // Two outermost pixels on each side of the cell.
        border_hit = (lo_x[CELL_SHIFT-1:1] == '0) || (lo_x[CELL_SHIFT-1:1] == '1) ||
                     (lo_y[CELL_SHIFT-1:1] == '0) || (lo_y[CELL_SHIFT-1:1] == '1);
    end

    // Stage 1: issue RAM address and latch per-pixel flags and syncs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            active_reg     <= 1'b0;
            board_reg      <= 1'b0;
            cursor_hit_reg <= 1'b0;
            border_reg     <= 1'b0;
            hs1_reg        <= 1'b1;
            vs1_reg        <= 1'b1;
            cell_addr_reg  <= '0;
        end else if (pix_en) begin
            active_reg     <= (h_reg < 10'd640) && (v_reg < 10'd480);
            board_reg      <= in_board;
            cursor_hit_reg <= cursor_hit;
            border_reg     <= border_hit;
            hs1_reg        <= !((h_reg >= 10'd656) && (h_reg <= 10'd751));
            vs1_reg        <= !((v_reg >= 10'd490) && (v_reg <= 10'd491));
            cell_addr_reg  <= in_board ? ADDR_W'(row_idx * 10'(GRID_COLS) + col_idx) : '0;
        end
    end

    // Cell status palette.
    always_comb begin
        pal_color = 12'h000;
        case (cell_data)
            4'd0: pal_color = 12'hfff;
            4'd1: pal_color = 12'h770;
            4'd2: pal_color = 12'h0f0;
            4'd3: pal_color = 12'h00f;
            4'd4: pal_color = 12'h700;
            4'd5: pal_color = 12'h070;
            4'd6: pal_color = 12'h007;
            4'd7: pal_color = 12'hff0;
            4'd8: pal_color = 12'h0ff;
            4'd9: pal_color = 12'hf00;
            default: pal_color = 12'h000;
        endcase
    end

    // Stage 2 colour priority: blanking, background, cursor, cell status.
    always_comb begin
        colour_next = pal_color;
        if (!active_reg)
            colour_next = 12'h000;
        else if (!board_reg)
            colour_next = BG_COLOR;
        else if (cursor_hit_reg && ((HILITE_MODE == 0) || border_reg))
            colour_next = CURSOR_COLOR;
    end

    // Stage 2: output registers keep syncs aligned with colour.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rgb_reg   <= '0;
            hsync_reg <= 1'b1;
            vsync_reg <= 1'b1;
        end else if (pix_en) begin
            rgb_reg   <= colour_next;
            hsync_reg <= hs1_reg;
            vsync_reg <= vs1_reg;
        end
    end

    assign btn_vec = {btn_down, btn_up, btn_right, btn_left};

    // Per-button edge detector and pending-move flag; an edge in the
    // frame_start clk survives into the next frame.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_btn
            logic prev_reg, pend_reg;
            assign rise[gi]    = btn_vec[gi] && !prev_reg;
            assign pending[gi] = pend_reg;
            // Track button level and accumulate rising edges.
            always_ff @(posedge clk) begin
                if (!reset) begin
                    prev_reg <= 1'b0;
                    pend_reg <= 1'b0;
                end else begin
                    prev_reg <= btn_vec[gi];
                    pend_reg <= frame_start ? rise[gi] : (pend_reg || rise[gi]);
                end
            end
        end
    endgenerate

    // Net cursor move with wrap or clamp at the board edges.
    always_comb begin
        cursor_col_next = cursor_col_reg;
        cursor_row_next = cursor_row_reg;
        if (pending[1] && !pending[0])
            cursor_col_next = (cursor_col_reg == COL_MAX) ? ((WRAP != 0) ? '0 : COL_MAX)
                                                          : cursor_col_reg + COL_W'(1);
        else if (pending[0] && !pending[1])
            cursor_col_next = (cursor_col_reg == '0) ? ((WRAP != 0) ? COL_MAX : '0)
                                                     : cursor_col_reg - COL_W'(1);
        if (pending[3] && !pending[2])
            cursor_row_next = (cursor_row_reg == ROW_MAX) ? ((WRAP != 0) ? '0 : ROW_MAX)
                                                          : cursor_row_reg + ROW_W'(1);
        else if (pending[2] && !pending[3])
            cursor_row_next = (cursor_row_reg == '0) ? ((WRAP != 0) ? ROW_MAX : '0)
                                                     : cursor_row_reg - ROW_W'(1);
    end

    // Cursor only moves at the start of a frame.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cursor_col_reg <= '0;
            cursor_row_reg <= '0;
        end else if (frame_start) begin
            cursor_col_reg <= cursor_col_next;
            cursor_row_reg <= cursor_row_next;
        end
    end

    assign cell_addr  = cell_addr_reg;
    assign cursor_col = cursor_col_reg;
    assign cursor_row = cursor_row_reg;
    assign hSync      = hsync_reg;
    assign vSync      = vsync_reg;
    assign {VGA_R, VGA_G, VGA_B} = rgb_reg;

endmodule

// File: tb/tb_mine_board_renderer.sv
// Directed bench: default-geometry instance for timing/cursor/reset checks,
// plus two small-cell instances (clamp/fill and wrap/border) for pixel colours.
module tb_mine_board_renderer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_a, reset_bc;
    logic [3:0] a_btn, b_btn, c_btn;   // {down, up, right, left}
    logic [4:0] a_addr, b_addr, c_addr;
    logic [3:0] a_data, b_data, c_data;
    logic [2:0] a_col, a_row, b_col, b_row, c_col, c_row;
    logic       a_fs, b_fs, c_fs, a_hs, b_hs, c_hs, a_vs, b_vs, c_vs;
    logic [3:0] a_r, a_g, a_b, b_r, b_g, b_b, c_r, c_g, c_b;

    int tests_run = 0;
    int failures  = 0;

    mine_board_renderer dut_a (
        .clk(clk), .reset(reset_a),
        .btn_left(a_btn[0]), .btn_right(a_btn[1]), .btn_up(a_btn[2]), .btn_down(a_btn[3]),
        .cell_addr(a_addr), .cell_data(a_data), .cursor_col(a_col), .cursor_row(a_row),
        .frame_start(a_fs), .hSync(a_hs), .vSync(a_vs), .VGA_R(a_r), .VGA_G(a_g), .VGA_B(a_b)
    );

    mine_board_renderer #(.CELL_SHIFT(3), .ORIGIN_X(64), .ORIGIN_Y(2), .PIX_DIV(2),
                          .WRAP(0), .HILITE_MODE(0), .BG_COLOR(12'h123)) dut_b (
        .clk(clk), .reset(reset_bc),
        .btn_left(b_btn[0]), .btn_right(b_btn[1]), .btn_up(b_btn[2]), .btn_down(b_btn[3]),
        .cell_addr(b_addr), .cell_data(b_data), .cursor_col(b_col), .cursor_row(b_row),
        .frame_start(b_fs), .hSync(b_hs), .vSync(b_vs), .VGA_R(b_r), .VGA_G(b_g), .VGA_B(b_b)
    );

    mine_board_renderer #(.CELL_SHIFT(3), .ORIGIN_X(64), .ORIGIN_Y(2), .PIX_DIV(2),
                          .WRAP(1), .HILITE_MODE(1)) dut_c (
        .clk(clk), .reset(reset_bc),
        .btn_left(c_btn[0]), .btn_right(c_btn[1]), .btn_up(c_btn[2]), .btn_down(c_btn[3]),
        .cell_addr(c_addr), .cell_data(c_data), .cursor_col(c_col), .cursor_row(c_row),
        .frame_start(c_fs), .hSync(c_hs), .vSync(c_vs), .VGA_R(c_r), .VGA_G(c_g), .VGA_B(c_b)
    );

    // Board contents: RAM[0]=3, RAM[1]=9, RAM[4]=1, RAM[6]=7, others 0.
    function automatic logic [3:0] ram_val(input logic [4:0] a);
        case (a)
            5'd0:    return 4'd3;
            5'd1:    return 4'd9;
            5'd4:    return 4'd1;
            5'd6:    return 4'd7;
            default: return 4'd0;
        endcase
    endfunction

    // Synchronous status RAM models, one clk read latency.
    always @(posedge clk) begin
        a_data <= ram_val(a_addr);
        b_data <= ram_val(b_addr);
        c_data <= ram_val(c_addr);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pixel table for instances B and C: 8 px cells, board x 64..103, y 2..41.
    // B cursor (1,1) fill, BG 123; C cursor (4,0) border-only, BG 000.
    int          px [13] = '{10, 63, 64, 72, 96, 104, 640, 98, 100, 103, 101, 64, 75};
    int          py [13] = '{ 0,  2,  2,  2,  2,   2,   2,  4,   5,   6,   9, 12, 12};
    logic [11:0] eb [13] = '{12'h123, 12'h123, 12'h00f, 12'hf00, 12'h770, 12'h123, 12'h000,
                             12'h770, 12'h770, 12'h770, 12'h770, 12'hfff, 12'h777};
    logic [11:0] ec [13] = '{12'h000, 12'h000, 12'h00f, 12'hf00, 12'h777, 12'h000, 12'h000,
                             12'h770, 12'h770, 12'h777, 12'h777, 12'hfff, 12'hff0};

    int   fall1, rise1, fall2, fs_cnt, fs_n, m, target;
    logic prev_hs, vs_seen_low;

    // Run instance A from reset release, recording sync edges and frame_start.
    task automatic run_a(input int cycles);
        fall1 = -1; rise1 = -1; fall2 = -1; fs_cnt = 0; fs_n = -1;
        prev_hs = 1'b1; vs_seen_low = 1'b0;
        for (int n = 1; n <= cycles; n++) begin
            @(posedge clk); #1;
            if (n == 5) begin
                a_btn = 4'b0000;
                check("a_cursor_col", 32'(a_col), 32'd0);
                check("a_cursor_row", 32'(a_row), 32'd0);
                $display("[TB] A cursor after frame_start = (%0d,%0d)", a_col, a_row);
            end
            if (a_fs) begin fs_cnt++; fs_n = n; end
            if (!a_vs) vs_seen_low = 1'b1;
            if (prev_hs && !a_hs) begin
                if (fall1 < 0) fall1 = n;
                else if (fall2 < 0) fall2 = n;
            end
            if (!prev_hs && a_hs && rise1 < 0) rise1 = n;
            prev_hs = a_hs;
        end
    endtask

    initial begin
        reset_a = 1'b0; reset_bc = 1'b0;
        a_btn = 4'b0101;          // left + up held through release: clamp at (0,0)
        b_btn = 4'b1010;          // right + down: (0,0) -> (1,1)
        c_btn = 4'b0001;          // left with wrap: (0,0) -> (4,0)

        // Reset state of instance A.
        repeat (3) @(posedge clk);
        #1;
        check("a_rst_hsync", 32'(a_hs), 32'd1);
        check("a_rst_vsync", 32'(a_vs), 32'd1);
        check("a_rst_rgb",   32'({a_r, a_g, a_b}), 32'd0);
        check("a_rst_fs",    32'(a_fs), 32'd0);
        check("a_rst_addr",  32'(a_addr), 32'd0);
        $display("[TB] A reset: hSync=%0b vSync=%0b rgb=%h", a_hs, a_vs, {a_r, a_g, a_b});

        @(negedge clk); reset_a = 1'b1;
        run_a(6000);
        check("a_fs_clk",       32'(fs_n), 32'd3);
        check("a_fs_count",     32'(fs_cnt), 32'd1);
        check("a_hsync_fall",   32'(fall1), 32'd2632);
        check("a_hsync_width",  32'(rise1 - fall1), 32'd384);
        check("a_line_period",  32'(fall2 - fall1), 32'd3200);
        check("a_vsync_idle",   32'(vs_seen_low), 32'd0);
        $display("[TB] A timing: fall=%0d rise=%0d next_fall=%0d fs_at=%0d", fall1, rise1, fall2, fs_n);

        // Mid-line reset with a pending move that must be discarded.
        a_btn = 4'b0010;
        repeat (2) @(posedge clk);
        #1 a_btn = 4'b0000;
        reset_a = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("a_mid_rst_hsync", 32'(a_hs), 32'd1);
        check("a_mid_rst_rgb",   32'({a_r, a_g, a_b}), 32'd0);
        check("a_mid_rst_addr",  32'(a_addr), 32'd0);
        check("a_mid_rst_col",   32'(a_col), 32'd0);
        @(negedge clk); reset_a = 1'b1;
        run_a(2700);
        check("a_restart_fs",    32'(fs_n), 32'd3);
        check("a_restart_fall",  32'(fall1), 32'd2632);
        $display("[TB] A restart: fall=%0d fs_at=%0d", fall1, fs_n);

        // Instances B and C: cursor moves then rendered pixels.
        #1;
        check("bc_rst_rgb", 32'({b_r, b_g, b_b}), 32'd0);
        check("bc_rst_hs",  32'(b_hs), 32'd1);
        @(negedge clk); reset_bc = 1'b1;
        m = 0;
        @(posedge clk); m++; #1;
        check("b_fs_high", 32'(b_fs), 32'd1);
        @(posedge clk); m++; #1;
        check("b_fs_low", 32'(b_fs), 32'd0);
        b_btn = 4'b0000; c_btn = 4'b0000;
        check("b_cursor_col", 32'(b_col), 32'd1);
        check("b_cursor_row", 32'(b_row), 32'd1);
        check("c_wrap_col",   32'(c_col), 32'd4);
        check("c_wrap_row",   32'(c_row), 32'd0);
        $display("[TB] B cursor=(%0d,%0d) C cursor=(%0d,%0d)", b_col, b_row, c_col, c_row);

        for (int k = 0; k < 13; k++) begin
            target = 4 + 2 * (py[k] * 800 + px[k]);
            while (m < target) begin
                @(posedge clk); m++;
            end
            #1;
            check($sformatf("b_pix_%0d_%0d", px[k], py[k]), 32'({b_r, b_g, b_b}), 32'(eb[k]));
            check($sformatf("c_pix_%0d_%0d", px[k], py[k]), 32'({c_r, c_g, c_b}), 32'(ec[k]));
            $display("[TB] pixel (%0d,%0d): B=%h C=%h", px[k], py[k], {b_r, b_g, b_b}, {c_r, c_g, c_b});
        end

        // Opposite directions cancel; an edge in the frame_start clk is deferred.
        reset_bc = 1'b0;
        b_btn = 4'b1011;
        repeat (3) @(posedge clk);
        @(negedge clk); reset_bc = 1'b1;
        @(posedge clk); #1;
        c_btn = 4'b0010;
        @(posedge clk); #1;
        check("b_cancel_col", 32'(b_col), 32'd0);
        check("b_cancel_row", 32'(b_row), 32'd1);
        check("c_late_col",   32'(c_col), 32'd0);
        check("c_late_row",   32'(c_row), 32'd0);
        $display("[TB] cancel B=(%0d,%0d) deferred C=(%0d,%0d)", b_col, b_row, c_col, c_row);

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end
endmodule

// File: doc/mine_board_renderer.md
Name: mine_board_renderer

Overview:
Parametrised successor of the board display controller. Generates 640x480 VGA timing from the 100 MHz system clock and renders a GRID_COLS x GRID_ROWS minesweeper board at a configurable origin and power-of-two cell size. Cell status comes from an external synchronous RAM. The block owns a frame-synchronous cursor with edge-detected buttons, wrap or clamp mode, and fill or border highlight. It sits between the game-state memory and the VGA pins.

Parameters:
GRID_COLS, 5, board columns (1..16)
GRID_ROWS, 5, board rows (1..16)
CELL_SHIFT, 6, log2 of cell edge in pixels (cell = 64 px)
ORIGIN_X, 64, left pixel of board
ORIGIN_Y, 64, top pixel of board
PIX_DIV, 4, system clocks per pixel
WRAP, 0, 1 = cursor wraps at edges; 0 = cursor clamps
HILITE_MODE, 0, 0 = fill cursor cell; 1 = 2-px border only
CURSOR_COLOR, 12'h777, highlight colour
BG_COLOR, 12'h000, colour outside board (active area)
Derived: ADDR_W = clog2(GRID_COLS*GRID_ROWS); COL_W = max(1, clog2(GRID_COLS)); ROW_W = max(1, clog2(GRID_ROWS))

Ports:
clk  in  1  100 MHz system clock
reset  in  1  synchronous, active-low reset
btn_left/btn_right/btn_up/btn_down  in  1 each  debounced button levels, clk domain
cell_addr  out  ADDR_W  status RAM read address
cell_data  in  4  status of cell_addr; valid exactly 1 clk after cell_addr changes
cursor_col  out  COL_W  current cursor column
cursor_row  out  ROW_W  current cursor row
frame_start  out  1  one-clk pulse when pixel (0,0) is issued
hSync, vSync  out  1 each  active-low syncs
VGA_R, VGA_G, VGA_B  out  4 each  colour

Behaviour:
- Reset (reset==0 at posedge clk): all counters = 0; cursor = (0,0); edge registers and pending moves cleared; hSync = vSync = 1; RGB = 0; frame_start = 0; cell_addr = 0. Reset mid-frame restarts at pixel (0,0) with no partial output.
- pix_en: divider counts 0..PIX_DIV-1; pix_en is high for one clk when count == PIX_DIV-1. All pixel-pipeline registers advance only on pix_en.
- Timing:
  - H: 800 pixels (640 active, 16 front porch, 96 sync, 48 back porch); hsync low for h in 656..751.
  - V: 525 lines (480 active, 10 front porch, 2 sync, 33 back porch); vsync low for v in 490..491.
  - v increments when h wraps 799->0.
- Stage 1 (on pix_en):
  - dx = x - ORIGIN_X, dy = y - ORIGIN_Y.
  - in_board = x >= ORIGIN_X && y >= ORIGIN_Y && (dx >> CELL_SHIFT) < GRID_COLS && (dy >> CELL_SHIFT) < GRID_ROWS.
  - cell_addr = row*GRID_COLS + col when in_board, else 0.
  - Also latch: active flag, in_board, is_cursor (col/row equal cursor), border (low-order dx or dy bits in {0, 1, 2^CELL_SHIFT-2, 2^CELL_SHIFT-1}), and syncs.
- Stage 2 (next pix_en; cell_data has been valid since stage1+1 clk): colour select. First matching rule applies:
  1. not active -> 0
  2. !in_board -> BG_COLOR
  3. is_cursor && (HILITE_MODE==0 || border) -> CURSOR_COLOR
  4. otherwise palette[cell_data]
- Palette:
  - 0 fff; 1 770; 2 0f0; 3 00f; 4 700; 5 070; 6 007; 7 ff0; 8 0ff; 9 f00
  - 10..15 -> 000
- Latency: RGB, hSync and vSync are all delayed by exactly 2 pixel periods relative to counters, so syncs remain aligned with pixel data.
- frame_start: asserted for the single clk in which the counters issue h=0, v=0.
- Buttons:
  - Register each button every clk. A 0->1 transition sets that direction's pending flag; holding a button gives a single move.
  - On frame_start, pending moves apply and all pending flags clear in the same clk.
  - Net dx = right - left, net dy = down - up; simultaneous opposite directions cancel.
  - Edges arriving in the same clk as frame_start are captured for the next frame.
- Edge rule:
  - WRAP=1: col 0 moving left -> GRID_COLS-1; col GRID_COLS-1 moving right -> 0; rows likewise.
  - WRAP=0: saturate at 0 and GRID_COLS-1 / GRID_ROWS-1.
- Cursor outputs are registered and change only in the frame_start clk.

Test Plan:
- Reset held 3 clks, then released -> hSync=vSync=1 and RGB=0 during reset; first hSync fall at pixel 656 + 2 latency = pixel 658 (2632 clks after release, ±PIX_DIV); line period 3200 clks; frame period 1,680,000 clks.
- cell_data model with RAM[0]=3, cursor at (1,1), pixel (64,64) -> cell_addr=0, output RGB=00f two pixels later; pixel (63,64) -> BG_COLOR 000; pixel (384,64) -> 000 (col 5 outside board).
- Cursor at (0,0), HILITE_MODE=0 -> every pixel of cell 0 reads 777. With HILITE_MODE=1 -> (64,64)=777, (66,66)=palette colour, (127,100)=777.
- WRAP=0: three btn_left pulses at cursor (0,2) -> cursor stays (0,2). WRAP=1: same stimulus -> after one frame_start, cursor=(4,2).
- btn_left and btn_right rising in the same clk, plus btn_down held for 3 frames -> after next frame_start cursor col unchanged, row +1 once only.
- Reset asserted mid-frame at pixel (300,200) with cursor (3,3) -> next released frame restarts at (0,0), cursor (0,0), no stale pending moves.
